// File: rtl/arm_reg_file.sv
// 32 x 64-bit register file with two combinational read ports, one write port,
// hardwired-zero XZR and write-through bypass so ID sees same-cycle WB data.
module arm_reg_file #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic                bypass_ok;

  always_comb begin
    wr_en = '0;
    if (RegWrite && (WriteRegister != ZERO_ADDR))
      wr_en[WriteRegister] = 1'b1;
  end

  // Reset gating keeps bypass quiet while storage is being cleared.
  assign bypass_ok = RegWrite && reset && (WriteRegister != ZERO_ADDR);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        mem[g] <= '0;
      else if (wr_en[g])
        mem[g] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = mem[ReadRegister1];
    if (ReadRegister1 == ZERO_ADDR)
      ReadData1 = '0;
    else if (bypass_ok && (WriteRegister == ReadRegister1))
      ReadData1 = WriteData;
  end

  always_comb begin
    ReadData2 = mem[ReadRegister2];
    if (ReadRegister2 == ZERO_ADDR)
      ReadData2 = '0;
    else if (bypass_ok && (WriteRegister == ReadRegister2))
      ReadData2 = WriteData;
  end

endmodule
